// File: rtl/ps2_mouse_cmd_seq.sv
// ps2_mouse_cmd_seq
// Command sequencer and byte scheduler that sits between a PS/2 transceiver
// and a mouse packet decoder. After reset it runs the mouse power-up
// sequence, then arbitrates the transmit path between stream forwarding and
// runtime host commands, checking every acknowledge with resend and timeouts.
//
// Optional feature macro: PS2_MOUSE_WHEEL_EN
//   Defined   : extended init list that unlocks the scroll wheel and
//               captures the device ID (03 -> wheel_present = 1).
//   Undefined : plain 4-step init list, wheel_present tied low.
module ps2_mouse_cmd_seq #(
    parameter int         TIMEOUT_CYCLES     = 2_500_000,
    parameter int         BAT_TIMEOUT_CYCLES = 50_000_000,
    parameter int         MAX_RETRY          = 3,
    parameter logic [7:0] SAMPLE_RATE        = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_done_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       stream_valid,
    output logic [7:0] stream_data,
    output logic       init_done,
    output logic       init_err,
    output logic       wheel_present
);

    // Mouse protocol bytes
    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_ERROR  = 8'hFC;
    localparam logic [7:0] B_BAT_OK = 8'hAA;
    localparam logic [7:0] B_ID_STD = 8'h00;

`ifdef PS2_MOUSE_WHEEL_EN
    // Magic sample-rate knock (200, 100, 80) followed by Get Device ID (F2)
    localparam int N_INIT  = 11;
    localparam int ID_STEP = 7;
    localparam logic [8*N_INIT-1:0] INIT_FLAT = {
        8'hF4, SAMPLE_RATE, 8'hF3, 8'hF2, 8'h50, 8'hF3,
        8'h64, 8'hF3, 8'hC8, 8'hF3, 8'hFF
    };
`else
    localparam int N_INIT = 4;
    localparam logic [8*N_INIT-1:0] INIT_FLAT = {8'hF4, SAMPLE_RATE, 8'hF3, 8'hFF};
`endif

    localparam int LAST_STEP = N_INIT - 1;
    localparam int T_MAX     = (BAT_TIMEOUT_CYCLES > TIMEOUT_CYCLES) ?
                               BAT_TIMEOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW        = $clog2(T_MAX + 1);
    localparam int SW        = $clog2(N_INIT);
    // retry counter must be able to hold MAX_RETRY + 1
    localparam int RW        = $clog2(MAX_RETRY + 2);

    localparam logic [TW-1:0] T_ACK = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_BAT = TW'(BAT_TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_TX,
        S_WAIT_TX,
        S_ACK,
        S_BAT,
        S_ID,
        S_WID,
        S_RUN,
        S_HTX,
        S_HWAIT,
        S_HACK,
        S_ERR
    } state_t;

    state_t          state_reg;
    logic [SW-1:0]   step_reg;
    logic [RW-1:0]   retry_reg;
    logic [TW-1:0]   timer_reg;
    logic            resent_reg;
    logic [7:0]      cmd_byte_reg;

    logic [7:0]      init_rom [N_INIT];
    logic            timer_zero;
    logic            init_fail;
    logic            host_fail;
    logic            cmd_fire;
    logic [RW-1:0]   retry_inc;

    // Unpack the init byte list into a small lookup table indexed by step
    for (genvar gi = 0; gi < N_INIT; gi++) begin : g_init_rom
        assign init_rom[gi] = INIT_FLAT[8*gi +: 8];
    end

    assign timer_zero = (timer_reg == '0);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign retry_inc  = retry_reg + RW'(1);

    // Failure detection: a received byte takes priority over a timer expiry
    // in the same cycle; a second FE on the same byte is a failure.
    always_comb begin
        init_fail = 1'b0;
        host_fail = 1'b0;
        case (state_reg)
            S_WAIT_TX: init_fail = !tx_done_tick && timer_zero;
            S_ACK: begin
                if (rx_done_tick) begin
                    init_fail = (rx_data == B_RESEND) ? resent_reg : (rx_data != B_ACK);
                end else begin
                    init_fail = timer_zero;
                end
            end
            S_BAT:     init_fail = rx_done_tick ? (rx_data != B_BAT_OK) : timer_zero;
            S_ID:      init_fail = rx_done_tick ? (rx_data != B_ID_STD) : timer_zero;
            S_WID:     init_fail = !rx_done_tick && timer_zero;
            S_HWAIT:   host_fail = !tx_done_tick && timer_zero;
            S_HACK: begin
                if (rx_done_tick) begin
                    host_fail = (rx_data == B_ERROR) ||
                                ((rx_data == B_RESEND) && resent_reg);
                end else begin
                    host_fail = timer_zero;
                end
            end
            default: begin
                init_fail = 1'b0;
                host_fail = 1'b0;
            end
        endcase
    end

    // Main sequencer: state, step/retry bookkeeping, timer and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_TX;
            step_reg      <= '0;
            retry_reg     <= '0;
            timer_reg     <= '0;
            resent_reg    <= 1'b0;
            cmd_byte_reg  <= 8'h00;
            wr_ps2        <= 1'b0;
            tx_data       <= 8'h00;
            cmd_ready     <= 1'b0;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            stream_valid  <= 1'b0;
            stream_data   <= 8'h00;
            init_done     <= 1'b0;
            init_err      <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_present <= 1'b0;
`endif
        end else begin
            wr_ps2       <= 1'b0;
            cmd_done     <= 1'b0;
            cmd_err      <= 1'b0;
            stream_valid <= 1'b0;

            if (init_fail) begin
                // Restart the whole init sequence, or give up for good
                retry_reg  <= retry_inc;
                resent_reg <= 1'b0;
                if (retry_inc > RW'(MAX_RETRY)) begin
                    state_reg <= S_ERR;
                    init_err  <= 1'b1;
                    init_done <= 1'b0;
                    cmd_ready <= 1'b0;
                end else begin
                    step_reg  <= '0;
                    state_reg <= S_TX;
                end
            end else if (host_fail) begin
                cmd_err   <= 1'b1;
                cmd_ready <= 1'b1;
                state_reg <= S_RUN;
            end else begin
                case (state_reg)
                    S_TX: begin
                        tx_data   <= init_rom[step_reg];
                        wr_ps2    <= 1'b1;
                        timer_reg <= T_ACK;
                        state_reg <= S_WAIT_TX;
                    end

                    S_WAIT_TX: begin
                        if (tx_done_tick) begin
                            timer_reg <= T_ACK;
                            state_reg <= S_ACK;
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end

                    S_ACK: begin
                        if (rx_done_tick) begin
                            if (rx_data == B_RESEND) begin
                                resent_reg <= 1'b1;
                                state_reg  <= S_TX;
                            end else begin
                                resent_reg <= 1'b0;
                                if (step_reg == '0) begin
                                    timer_reg <= T_BAT;
                                    state_reg <= S_BAT;
`ifdef PS2_MOUSE_WHEEL_EN
                                end else if (step_reg == SW'(ID_STEP)) begin
                                    timer_reg <= T_ACK;
                                    state_reg <= S_WID;
`endif
                                end else if (step_reg == SW'(LAST_STEP)) begin
                                    init_done <= 1'b1;
                                    cmd_ready <= 1'b1;
                                    state_reg <= S_RUN;
                                end else begin
                                    step_reg  <= step_reg + SW'(1);
                                    state_reg <= S_TX;
                                end
                            end
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end

                    S_BAT: begin
                        if (rx_done_tick) begin
                            timer_reg <= T_BAT;
                            state_reg <= S_ID;
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end

                    S_ID: begin
                        if (rx_done_tick) begin
                            step_reg  <= SW'(1);
                            state_reg <= S_TX;
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end

`ifdef PS2_MOUSE_WHEEL_EN
                    S_WID: begin
                        if (rx_done_tick) begin
                            wheel_present <= (rx_data == 8'h03);
                            step_reg      <= step_reg + SW'(1);
                            state_reg     <= S_TX;
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end
`endif

                    S_RUN: begin
                        // A byte and a command in the same cycle are both served
                        if (rx_done_tick) begin
                            stream_valid <= 1'b1;
                            stream_data  <= rx_data;
                        end
                        if (cmd_fire) begin
                            cmd_byte_reg <= cmd_data;
                            resent_reg   <= 1'b0;
                            cmd_ready    <= 1'b0;
                            state_reg    <= S_HTX;
                        end
                    end

                    S_HTX: begin
                        tx_data   <= cmd_byte_reg;
                        wr_ps2    <= 1'b1;
                        timer_reg <= T_ACK;
                        state_reg <= S_HWAIT;
                    end

                    S_HWAIT: begin
                        if (tx_done_tick) begin
                            timer_reg <= T_ACK;
                            state_reg <= S_HACK;
                        end else if (!timer_zero) begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end

                    S_HACK: begin
                        if (rx_done_tick && (rx_data == B_ACK)) begin
                            cmd_done  <= 1'b1;
                            cmd_ready <= 1'b1;
                            state_reg <= S_RUN;
                        end else if (rx_done_tick && (rx_data == B_RESEND)) begin
                            resent_reg <= 1'b1;
                            state_reg  <= S_HTX;
                        end else begin
                            // Mid-packet stream bytes still reach the decoder
                            if (rx_done_tick) begin
                                stream_valid <= 1'b1;
                                stream_data  <= rx_data;
                            end
                            if (!timer_zero) begin
                                timer_reg <= timer_reg - TW'(1);
                            end
                        end
                    end

                    S_ERR: begin
                        init_err  <= 1'b1;
                        init_done <= 1'b0;
                        cmd_ready <= 1'b0;
                    end

                    default: state_reg <= S_ERR;
                endcase
            end
        end
    end

`ifndef PS2_MOUSE_WHEEL_EN
    assign wheel_present = 1'b0;
`endif

endmodule
